// File: rtl/cluster_pkg.sv
// Shared definitions for the K-means cluster statistics datapath.
package cluster_pkg;

    localparam int PW_DEF = 8;
    localparam int CH_DEF = 3;
    localparam int NW_DEF = 12;
    localparam int AW_DEF = 20;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    function automatic logic [63:0] ch_slice(
        input logic [63:0] pix,
        input int          idx,
        input int          pw
    );
        logic [63:0] mask;
        mask = (64'd1 << pw) - 64'd1;
        return (pix >> (idx * pw)) & mask;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, zero-divisor bypass.
module seq_divider #(
    parameter int AW = 20,
    parameter int DW = 12,
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [OW-1:0] quotient,
    output logic          done
);

    localparam int CW = $clog2(AW + 1);
    // Remainder stays below the divisor, so one bit narrower than AW suffices.
    localparam int RW = AW - 1;

    logic [AW-1:0] quo_q, quo_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;
    logic [AW-1:0] shifted;
    logic [AW-1:0] dvs_ext;

    assign shifted = {rem_q, quo_q[AW-1]};
    assign dvs_ext = AW'(dvs_q);

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = done_q;
        if (start) begin
            dvs_d  = divisor;
            rem_d  = '0;
            cnt_d  = CW'(AW);
            run_d  = (divisor != '0);
            done_d = (divisor == '0);
            quo_d  = (divisor == '0) ? '0 : dividend;
        end else if (run_q) begin
            if (shifted >= dvs_ext) begin
                rem_d = RW'(shifted - dvs_ext);
                quo_d = {quo_q[AW-2:0], 1'b1};
            end else begin
                rem_d = RW'(shifted);
                quo_d = {quo_q[AW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q[OW-1:0];
    assign done     = done_q;

endmodule

// File: rtl/cluster_mean_unit.sv
// Per-cluster channel sums and pixel count, divided into a new centroid
// while the next pass keeps accumulating.
module cluster_mean_unit
    import cluster_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int CH = CH_DEF,
    parameter int NW = NW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic             group,
    input  logic [CH*PW-1:0] pixel_in,
    input  logic             pass_end,
    output logic [CH*PW-1:0] mean_out,
    output logic [NW-1:0]    count_out,
    output logic             ovf_out,
    output logic             empty_out,
    output logic             mean_valid,
    input  logic             mean_ready,
    output logic             busy,
    output logic             pass_err
);

    if (AW < PW + NW) begin : g_aw_chk
        $error("cluster_mean_unit: AW must be >= PW+NW");
    end

    localparam logic [NW-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [AW-1:0]    sum_q [CH];
    logic [AW-1:0]    sum_d [CH];
    logic [NW-1:0]    cnt_q, cnt_d, cnt_b;
    logic             ovf_q, ovf_d;
    logic [CH*PW-1:0] mean_q, mean_d;
    logic [NW-1:0]    cnt_out_q, cnt_out_d;
    logic             ovf_out_q, ovf_out_d;
    logic             empty_q, empty_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [PW-1:0]    div_quo [CH];
    logic [CH-1:0]    div_done;
    logic             accept;
    logic             start;

    assign accept = pix_valid & group;
    assign start  = pass_end & (state_q == ST_ACCUM);
    // A pixel arriving with the snapshot belongs to the new pass.
    assign cnt_b  = start ? '0 : cnt_q;

    always_comb begin
        cnt_d = cnt_b;
        ovf_d = start ? 1'b0 : ovf_q;
        for (int i = 0; i < CH; i++) begin
            sum_d[i] = start ? '0 : sum_q[i];
        end
        if (accept) begin
            if (cnt_b != CNT_MAX) begin
                cnt_d = cnt_b + NW'(1);
                for (int i = 0; i < CH; i++) begin
                    sum_d[i] = sum_d[i]
                             + AW'(PW'(ch_slice(64'(pixel_in), i, PW)));
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mean_d    = mean_q;
        cnt_out_d = cnt_out_q;
        ovf_out_d = ovf_out_q;
        empty_d   = empty_q;
        valid_d   = valid_q;
        err_d     = err_q;
        unique case (state_q)
            ST_ACCUM: begin
                if (pass_end) begin
                    cnt_out_d = cnt_q;
                    ovf_out_d = ovf_q;
                    state_d   = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (pass_end) err_d = 1'b1;
                if (&div_done) begin
                    for (int i = 0; i < CH; i++) begin
                        mean_d[i*PW +: PW] = div_quo[i];
                    end
                    empty_d = (cnt_out_q == '0);
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pass_end) err_d = 1'b1;
                if (mean_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ACCUM;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            mean_q    <= '0;
            cnt_out_q <= '0;
            ovf_out_q <= 1'b0;
            empty_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < CH; i++) sum_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            mean_q    <= mean_d;
            cnt_out_q <= cnt_out_d;
            ovf_out_q <= ovf_out_d;
            empty_q   <= empty_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            for (int i = 0; i < CH; i++) sum_q[i] <= sum_d[i];
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_div
        seq_divider #(
            .AW(AW),
            .DW(NW),
            .OW(PW)
        ) u_div (
            .clk     (clk),
            .reset   (reset),
            .start   (start),
            .dividend(sum_q[g]),
            .divisor (cnt_q),
            .quotient(div_quo[g]),
            .done    (div_done[g])
        );
    end

    assign mean_out   = mean_q;
    assign count_out  = cnt_out_q;
    assign ovf_out    = ovf_out_q;
    assign empty_out  = empty_q;
    assign mean_valid = valid_q;
    assign busy       = (state_q != ST_ACCUM);
    assign pass_err   = err_q;

endmodule
